ss_display_scheduler: RTL and testbench
=======================================

# ss_display_scheduler

Time-shares the 4-digit seven-segment display between three requesters: live clock, setting menu, and status/alarm message. Sits in front of SS_Driver. Drives its four BCD digit inputs and its 8-bit PWM duty input `in`. Each ownership change is sequenced as fade-out of the old owner, then fade-in of the new one. A minimum hold time stops a higher-priority requester from flickering the display.

## Interface
- TICK_DIV, 100000: Clk cycles per scheduler tick (1 kHz at 100 MHz).
- HOLD_TICKS, 500: minimum ticks an owner stays in SHOW before it can be preempted.
- FADE_STEP, 8: duty change per tick during a fade.

- Clk  input  1  system clock (100 MHz); all logic on its rising edge.
- Reset  input  1  synchronous, active-low reset.
- Req  input  3  request per requester, held high while it wants the display; index 2 has the highest priority.
- Data0, Data1, Data2  input  16 each  packed digits {BCD3,BCD2,BCD1,BCD0} of each requester.
- Brightness  input  8  target full-on duty.
- Grant  output  3  one-hot owner of the display, registered.
- Released  output  3  one-cycle pulse when a former owner has fully faded out.
- BCD3, BCD2, BCD1, BCD0  output  4 each  digits to SS_Driver, registered.
- Duty  output  8  PWM duty to SS_Driver `in`, registered.
- Busy  output  1  high in every state except IDLE.

## Operation
- **Reset (Reset=0 at a Clk edge):**
  - State IDLE; Grant=0, Released=0, BCD*=0, Duty=0, Busy=0.
  - Prescaler and hold counter cleared.
  - Applies mid-fade or mid-show with no Released pulse.
- **Prescaler:** counts 0..TICK_DIV-1 and emits a one-cycle `tick` on the cycle it wraps to 0.
- **Owner selection:** the highest-index asserted Req bit.
- **IDLE:**
  - If any Req is high, latch the selected owner.
  - Grant=onehot(owner); hold counter cleared; go to FADE_IN.
- **FADE_IN:**
  - On tick: Duty = min(Duty+FADE_STEP, Brightness), computed 9-bit with no wrap.
  - When the result equals Brightness, go to SHOW.
  - If the owner's Req drops, go to FADE_OUT from the current Duty.
  - If Brightness is below the current Duty, saturate to Brightness and go to SHOW.
- **SHOW:**
  - Duty follows Brightness every cycle.
  - Hold counter increments on tick and saturates at HOLD_TICKS.
  - Owner Req low → FADE_OUT immediately; hold time does not apply.
  - A higher-priority Req high with hold counter == HOLD_TICKS → FADE_OUT.
  - A lower-priority Req never preempts.
- **FADE_OUT:**
  - On tick: Duty = max(Duty-FADE_STEP, 0), no underflow.
  - When Duty reaches 0, pulse Released[old owner] for one cycle and clear Grant in the same cycle.
  - If any Req is high in that cycle, select the new owner and go directly to FADE_IN, with Grant set the following cycle. Otherwise go to IDLE.
- **Digits:** while Grant != 0, BCD* are loaded every cycle from the owner's Data (live update). In IDLE, BCD* hold their last value; the display is dark because Duty=0.
- **Duty during handover:** Duty is never nonzero while BCD* show a different owner's data. The switch to the new owner's data happens only at Duty=0.
- **Short requests:** a Req pulse shorter than one Clk cycle between IDLE samples is not remembered. Requesters hold Req until Grant.

## Timing
- Req rising in IDLE → Grant and Busy high on the next edge (1-cycle latency).
- Data change during SHOW → BCD* updated on the next edge.
- Brightness change during SHOW → Duty updated on the next edge.
- Fade-in duration is ceil(Brightness/FADE_STEP) ticks. Each tick position depends on prescaler phase, which is free-running and not realigned on grant.
- Released pulse is one cycle wide, coincident with Duty=0 registered.
- Simultaneous owner-drop and higher-priority Req in SHOW: FADE_OUT, then hand over to the highest Req present when Duty reaches 0.
- Brightness=0: FADE_IN exits to SHOW on its first evaluation without waiting for a tick.

## Test plan
All scenarios use TICK_DIV=4, HOLD_TICKS=3, FADE_STEP=64, Brightness=200.

1. **Reset:** hold Reset=0 for 3 cycles with Req=3'b111 → Grant=0, Duty=0, BCD*=0, Busy=0 throughout. After release, Grant=3'b100 one cycle later.
2. **Single fade-in:** Req=3'b001, Data0=16'h1234 → Grant=3'b001 after 1 cycle. Duty goes 64, 128, 192, 200 on successive ticks, then SHOW. BCD3..0 = 1,2,3,4.
3. **Preemption:** from test 2 in SHOW, raise Req[2] before 3 ticks have elapsed → no change until the hold counter reaches 3. Then Duty goes 136, 72, 8, 0; Released=3'b001 pulses; Grant=3'b100 next cycle; BCD shows Data2.
4. **No preemption by lower priority:** owner Req[1] in SHOW, raise Req[0] for 20 ticks → Grant stays 3'b010 and Duty stays 200.
5. **Owner drop mid-fade-in:** drop Req[0] at Duty=128 → Duty goes 64, 0; Released[0] pulses; state IDLE; Busy=0.
6. **Reset mid-show:** Reset=0 during SHOW → Duty=0 and Grant=0 on the next edge, with no Released pulse.

Source files
------------

// File: rtl/ss_display_scheduler.sv
// Time-shares a 4-digit seven-segment display between three requesters, with
// fade-out/fade-in handover and a minimum hold time before preemption.
module ss_display_scheduler #(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned HOLD_TICKS = 500,
    parameter int unsigned FADE_STEP  = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [2:0]  Req,
    input  logic [15:0] Data0,
    input  logic [15:0] Data1,
    input  logic [15:0] Data2,
    input  logic [7:0]  Brightness,
    output logic [2:0]  Grant,
    output logic [2:0]  Released,
    output logic [3:0]  BCD3,
    output logic [3:0]  BCD2,
    output logic [3:0]  BCD1,
    output logic [3:0]  BCD0,
    output logic [7:0]  Duty,
    output logic        Busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
    localparam logic [8:0]    STEP9    = 9'(FADE_STEP);

    typedef enum logic [1:0] {StIdle, StFadeIn, StShow, StFadeOut} state_e;

    state_e      state_q, state_d;
    logic [PW-1:0] pre_q;
    logic        tick;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]  owner_q, owner_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  rel_q, rel_d;
    logic [7:0]  duty_q, duty_d;
    logic [15:0] bcd_q, bcd_d;

    logic        own_req, higher_req;
    logic [8:0]  sum;
    logic [7:0]  inc_duty, dec_duty, out_duty;
    logic [15:0] data_sel;

    function automatic logic [1:0] pick(input logic [2:0] r);
        if (r[2]) return 2'd2;
        if (r[1]) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    assign tick = (pre_q == PRE_MAX);

    always_ff @(posedge Clk) begin
        if (!Reset) pre_q <= '0;
        else        pre_q <= tick ? '0 : pre_q + PW'(1);
    end

    always_comb begin
        own_req    = 1'b0;
        higher_req = 1'b0;
        case (owner_q)
            2'd0:    begin own_req = Req[0]; higher_req = |Req[2:1]; end
            2'd1:    begin own_req = Req[1]; higher_req = Req[2];    end
            2'd2:    begin own_req = Req[2]; higher_req = 1'b0;      end
            default: begin own_req = 1'b0;   higher_req = 1'b0;      end
        endcase
    end

    // 9-bit arithmetic so a full-scale step cannot wrap past Brightness or 0.
    assign sum      = {1'b0, duty_q} + STEP9;
    assign inc_duty = (sum > {1'b0, Brightness}) ? Brightness : sum[7:0];
    assign dec_duty = ({1'b0, duty_q} > STEP9) ? (duty_q - STEP9[7:0]) : 8'd0;
    assign out_duty = tick ? dec_duty : duty_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant_q;
        rel_d   = '0;
        duty_d  = duty_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (|Req) begin
                    owner_d = pick(Req);
                    grant_d = onehot(pick(Req));
                    hold_d  = '0;
                    state_d = StFadeIn;
                end
            end
            StFadeIn: begin
                grant_d = onehot(owner_q);
                if (!own_req) begin
                    state_d = StFadeOut;
                end else if (Brightness <= duty_q) begin
                    duty_d  = Brightness;
                    state_d = StShow;
                end else if (tick) begin
                    duty_d = inc_duty;
                    if (inc_duty == Brightness) state_d = StShow;
                end
            end
            StShow: begin
                grant_d = onehot(owner_q);
                duty_d  = Brightness;
                if (tick && hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
                if (!own_req || (higher_req && hold_q == HOLD_MAX)) state_d = StFadeOut;
            end
            StFadeOut: begin
                grant_d = onehot(owner_q);
                duty_d  = out_duty;
                // Grant drops with the release; a new owner's grant follows a cycle later.
                if (out_duty == 8'd0) begin
                    rel_d   = onehot(owner_q);
                    grant_d = '0;
                    hold_d  = '0;
                    if (|Req) begin
                        owner_d = pick(Req);
                        state_d = StFadeIn;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (owner_d)
            2'd2:    data_sel = Data2;
            2'd1:    data_sel = Data1;
            default: data_sel = Data0;
        endcase
        bcd_d = (grant_d != 3'b000) ? data_sel : bcd_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StIdle;
            owner_q <= 2'd0;
            grant_q <= '0;
            rel_q   <= '0;
            duty_q  <= '0;
            hold_q  <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            rel_q   <= rel_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            bcd_q   <= bcd_d;
        end
    end

    assign Grant    = grant_q;
    assign Released = rel_q;
    assign Duty     = duty_q;
    assign {BCD3, BCD2, BCD1, BCD0} = bcd_q;
    assign Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ss_display_scheduler.sv
// Directed bench for ss_display_scheduler: table-driven owner selection and fade
// steps, plus hand-written hold, saturation and reset sequences.
module tb_ss_display_scheduler;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [2:0]  Req = 3'b111;
    logic [15:0] Data0 = 16'h1234;
    logic [15:0] Data1 = 16'h5678;
    logic [15:0] Data2 = 16'h9021;
    logic [7:0]  Brightness = 8'd200;
    logic [2:0]  Grant, Released;
    logic [3:0]  BCD3, BCD2, BCD1, BCD0;
    logic [7:0]  Duty;
    logic        Busy;

    int n_cmp = 0;
    int n_bad = 0;

    ss_display_scheduler #(
        .TICK_DIV  (4),
        .HOLD_TICKS(3),
        .FADE_STEP (64)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req       (Req),
        .Data0     (Data0),
        .Data1     (Data1),
        .Data2     (Data2),
        .Brightness(Brightness),
        .Grant     (Grant),
        .Released  (Released),
        .BCD3      (BCD3),
        .BCD2      (BCD2),
        .BCD1      (BCD1),
        .BCD0      (BCD0),
        .Duty      (Duty),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  grant;
        logic [15:0] bcd;
    } sel_t;

    typedef struct {
        logic [7:0] duty;
        logic [2:0] grant;
        logic [2:0] rel;
    } step_t;

    sel_t  sel_tab[7];
    step_t steps[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        Req   = 3'b000;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
    endtask

    // Waits (bounded) for the next Duty change; a timeout is a failed comparison.
    task automatic run_steps(input int lo, input int hi, input string nm);
        logic [7:0] prev;
        bit         ok;
        for (int i = lo; i <= hi; i++) begin
            prev = Duty;
            ok   = 1'b0;
            for (int c = 0; c < 16; c++) begin
                @(negedge Clk);
                if (Duty != prev) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s[%0d] timeout: Duty stuck at %0d, expected %0d",
                         nm, i, Duty, steps[i].duty);
            end else begin
                check($sformatf("%s[%0d] duty", nm, i), 32'(Duty), 32'(steps[i].duty));
                check($sformatf("%s[%0d] grant", nm, i), 32'(Grant), 32'(steps[i].grant));
                check($sformatf("%s[%0d] released", nm, i), 32'(Released), 32'(steps[i].rel));
            end
        end
    endtask

    task automatic wait_duty(input logic [7:0] target, input string nm);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (Duty == target) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL %s: Duty never reached %0d, last %0d", nm, target, Duty);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel_tab[0] = '{3'b001, 3'b001, 16'h1234};
        sel_tab[1] = '{3'b010, 3'b010, 16'h5678};
        sel_tab[2] = '{3'b011, 3'b010, 16'h5678};
        sel_tab[3] = '{3'b100, 3'b100, 16'h9021};
        sel_tab[4] = '{3'b101, 3'b100, 16'h9021};
        sel_tab[5] = '{3'b110, 3'b100, 16'h9021};
        sel_tab[6] = '{3'b111, 3'b100, 16'h9021};

        steps[0]  = '{8'd64,  3'b001, 3'b000};
        steps[1]  = '{8'd128, 3'b001, 3'b000};
        steps[2]  = '{8'd192, 3'b001, 3'b000};
        steps[3]  = '{8'd200, 3'b001, 3'b000};
        steps[4]  = '{8'd136, 3'b001, 3'b000};
        steps[5]  = '{8'd72,  3'b001, 3'b000};
        steps[6]  = '{8'd8,   3'b001, 3'b000};
        steps[7]  = '{8'd0,   3'b000, 3'b001};
        steps[8]  = '{8'd64,  3'b100, 3'b000};
        steps[9]  = '{8'd128, 3'b100, 3'b000};
        steps[10] = '{8'd192, 3'b100, 3'b000};
        steps[11] = '{8'd200, 3'b100, 3'b000};
        steps[12] = '{8'd64,  3'b001, 3'b000};
        steps[13] = '{8'd128, 3'b001, 3'b000};
        steps[14] = '{8'd64,  3'b001, 3'b000};
        steps[15] = '{8'd0,   3'b000, 3'b001};

        // Reset held with all requests high
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("rst grant", 32'(Grant), 32'd0);
            check("rst duty", 32'(Duty), 32'd0);
            check("rst bcd", 32'({BCD3, BCD2, BCD1, BCD0}), 32'd0);
            check("rst busy", 32'(Busy), 32'd0);
            check("rst released", 32'(Released), 32'd0);
        end
        Reset = 1'b1;
        @(negedge Clk);
        check("post-rst grant", 32'(Grant), 32'b100);
        check("post-rst busy", 32'(Busy), 32'd1);

        // Owner selection from IDLE
        for (int i = 0; i < 7; i++) begin
            do_reset();
            Req = sel_tab[i].req;
            @(negedge Clk);
            check($sformatf("sel[%0d] grant", i), 32'(Grant), 32'(sel_tab[i].grant));
            check($sformatf("sel[%0d] bcd", i), 32'({BCD3, BCD2, BCD1, BCD0}),
                  32'(sel_tab[i].bcd));
            check($sformatf("sel[%0d] busy", i), 32'(Busy), 32'd1);
        end

        // Single fade-in, then preemption after hold
        do_reset();
        Req = 3'b001;
        @(negedge Clk);
        check("fadein grant", 32'(Grant), 32'b001);
        check("fadein duty0", 32'(Duty), 32'd0);
        run_steps(0, 3, "fadein");
        check("show bcd", 32'({BCD3, BCD2, BCD1, BCD0}), 32'h1234);
        Req = 3'b101;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            check("hold grant", 32'(Grant), 32'b001);
            check("hold duty", 32'(Duty), 32'd200);
        end
        run_steps(4, 7, "preempt");
        check("fadeout bcd", 32'({BCD3, BCD2, BCD1, BCD0}), 32'h1234);
        @(negedge Clk);
        check("handover grant", 32'(Grant), 32'b100);
        check("handover released", 32'(Released), 32'b000);
        check("handover duty", 32'(Duty), 32'd0);
        check("handover bcd", 32'({BCD3, BCD2, BCD1, BCD0}), 32'h9021);
        run_steps(8, 11, "newowner");

        // Lower priority never preempts; live Data/Brightness follow
        do_reset();
        Req = 3'b010;
        wait_duty(8'd200, "lowpri reach show");
        Req = 3'b011;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            check("lowpri grant", 32'(Grant), 32'b010);
            check("lowpri duty", 32'(Duty), 32'd200);
        end
        Brightness = 8'd150;
        Data1      = 16'h4321;
        @(negedge Clk);
        check("live duty", 32'(Duty), 32'd150);
        check("live bcd", 32'({BCD3, BCD2, BCD1, BCD0}), 32'h4321);
        Brightness = 8'd200;
        Data1      = 16'h5678;

        // Brightness lowered below Duty mid fade-in saturates straight to SHOW
        do_reset();
        Req = 3'b001;
        @(negedge Clk);
        run_steps(12, 13, "sat");
        Brightness = 8'd100;
        @(negedge Clk);
        check("sat duty", 32'(Duty), 32'd100);
        Brightness = 8'd120;
        @(negedge Clk);
        check("sat show follows", 32'(Duty), 32'd120);
        Brightness = 8'd200;

        // Owner drop mid fade-in
        do_reset();
        Req = 3'b001;
        @(negedge Clk);
        run_steps(12, 13, "drop");
        Req = 3'b000;
        run_steps(14, 15, "drop");
        check("drop busy at release", 32'(Busy), 32'd0);
        @(negedge Clk);
        check("drop released cleared", 32'(Released), 32'd0);
        check("drop idle grant", 32'(Grant), 32'd0);
        check("drop idle busy", 32'(Busy), 32'd0);
        check("drop idle duty", 32'(Duty), 32'd0);

        // Reset mid-show
        do_reset();
        Req = 3'b100;
        wait_duty(8'd200, "rstshow reach show");
        Reset = 1'b0;
        @(negedge Clk);
        check("rstshow duty", 32'(Duty), 32'd0);
        check("rstshow grant", 32'(Grant), 32'd0);
        check("rstshow released", 32'(Released), 32'd0);
        check("rstshow busy", 32'(Busy), 32'd0);
        Reset = 1'b1;
        Req   = 3'b000;
        @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
